icache_ctrl: RTL and testbench

Direct-mapped instruction cache between the PC register and the instruction memory. Uses the current PC to return a 32-bit instruction on a hit in the same cycle. On a miss it asserts `stall_o` so the PC and front-end hold, refills one 256-bit line over a request/acknowledge memory port, and then releases the stall.

---
 rtl/icache_ctrl.sv | 116 +++++++++++
 tb/tb_icache_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Returns a 32-bit instruction combinationally on a hit; on a miss it stalls
// the front-end, refills one 256-bit line over a req/ack port, then releases.
module icache_ctrl #(
  parameter int          LINES = 16,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [31:0]  pc_i,
  input  logic         flush_i,
  output logic [31:0]  instr_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 27 - IW;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [26:0]         miss_line_q, miss_line_d;  // pc[31:5] of the line being refilled
  logic [TW-1:0]       tag_q  [LINES];
  logic [255:0]        data_q [LINES];

  logic [2:0]          offset;
  logic [IW-1:0]       index;
  logic [TW-1:0]       tag;
  logic                hit;
  logic [IW-1:0]       fill_index;
  logic [TW-1:0]       fill_tag;
  logic                fill;
  logic                unused_pc_bits;

  assign offset         = pc_i[4:2];
  assign index          = pc_i[4+IW:5];
  assign tag            = pc_i[31:5+IW];
  assign hit            = req_i & valid_q[index] & (tag_q[index] == tag);
  assign fill_index     = miss_line_q[IW-1:0];
  assign fill_tag       = miss_line_q[26:IW];
  assign fill           = (state_q == MISS) & mem_ack_i;
  assign unused_pc_bits = ^pc_i[1:0];

  // Control state: FSM, valid bits and the latched miss address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Tag/data arrays are plain storage; the valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[fill_index] <= mem_data_i;
      tag_q[fill_index]  <= fill_tag;
    end
  end

  // Next-state logic; a flush overrides a refill landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_line_d = miss_line_q;
    case (state_q)
      IDLE: begin
        if (req_i && !hit) begin
          state_d     = MISS;
          miss_line_d = pc_i[31:5];
        end
      end
      MISS: begin
        if (mem_ack_i) begin
          state_d             = IDLE;
          valid_d[fill_index] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) valid_d = '0;
  end

  // Outputs; held at their idle values while reset is asserted.
  always_comb begin
    instr_o      = NOP;
    stall_o      = 1'b0;
    mem_enable_o = 1'b0;
    mem_addr_o   = '0;
    if (rst_i) begin
      case (state_q)
        IDLE: begin
          if (hit) instr_o = data_q[index][{offset, 5'b00000} +: 32];
          else if (req_i) stall_o = 1'b1;
        end
        MISS: begin
          stall_o      = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {miss_line_q, 5'b00000};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a queue-based scoreboard of expected
// instructions and an independent line-content model.
module tb_icache_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic [31:0]  pc;
  logic         flush;
  logic [31:0]  instr;
  logic         stall;
  logic         men;
  logic [31:0]  maddr;
  logic         ack;
  logic [255:0] mdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  icache_ctrl #(.LINES(16), .NOP(NOP)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .pc_i(pc), .flush_i(flush),
    .instr_o(instr), .stall_o(stall), .mem_enable_o(men), .mem_addr_o(maddr),
    .mem_ack_i(ack), .mem_data_i(mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every word is derived from its own address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h0050_0090;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = word_of({a[31:5], w[2:0], 2'b00});
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tg);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tg, instr, e);
  endtask

  // Fetch expected to hit: zero stall, data straight from the model.
  task automatic hit(input logic [31:0] a);
    @(negedge clk); req = 1'b1; pc = a;
    exp_q.push_back(word_of(a));
    #1;
    chk("hit_stall", stall, 0);
    chk("hit_men", men, 0);
    pop_chk("hit_instr");
  endtask

  // Fetch expected to miss; ack arrives in refill cycle k. With fl set the
  // ack coincides with a flush, so one further refill must follow.
  task automatic miss(input logic [31:0] a, input int k, input bit fl);
    bit f;
    f = fl;
    @(negedge clk); req = 1'b1; pc = a;
    exp_q.push_back(word_of(a));
    #1;
    chk("miss_stall0", stall, 1);
    chk("miss_men0", men, 0);
    repeat (2) begin
      for (int c = 1; c <= k; c++) begin
        @(negedge clk);
        pc = $urandom;
        if (c == k) begin
          ack = 1'b1; mdata = line_of(a); flush = f;
        end
        #1;
        chk("refill_men", men, 1);
        chk("refill_addr", maddr, {a[31:5], 5'b0});
        chk("refill_stall", stall, 1);
        chk("refill_instr", instr, NOP);
      end
      @(negedge clk); ack = 1'b0; flush = 1'b0; mdata = rand_line(); pc = a;
      #1;
      chk("after_men", men, 0);
      if (!f) begin
        chk("after_stall", stall, 0);
        pop_chk("after_instr");
        break;
      end
      chk("reflush_stall", stall, 1);
      f = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; pc = 32'h0; flush = 1'b0; ack = 1'b0; mdata = rand_line();

    // Reset: outputs forced idle even with a missing request present.
    @(negedge clk); #1;
    chk("rst_stall", stall, 0);
    chk("rst_men", men, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_addr", maddr, 0);
    @(negedge clk); rst_n = 1'b1; req = 1'b0;

    // First fill of line 0, ack in cycle 3.
    miss(32'h0000_0000, 3, 1'b0);
    for (int i = 1; i < 8; i++) hit(32'h0000_0000 + 32'(4 * i));

    // Next line: minimum-penalty refill.
    miss(32'h0000_0020, 1, 1'b0);
    hit(32'h0000_0024);

    // Conflict on index 0.
    miss(32'h0000_0200, 2, 1'b0);
    hit(32'h0000_0208);
    miss(32'h0000_0000, 2, 1'b0);

    // Idle request returns NOP; flush pulse invalidates line 0.
    @(negedge clk); req = 1'b0; flush = 1'b1; #1;
    chk("idle_instr", instr, NOP);
    chk("idle_stall", stall, 0);
    @(negedge clk); flush = 1'b0;
    miss(32'h0000_0000, 1, 1'b0);

    // Flush landing together with the ack forces a second refill.
    miss(32'h0000_0020, 2, 1'b1);
    hit(32'h0000_003C);

    // Reset two cycles after mem_enable rises aborts the refill.
    @(negedge clk); req = 1'b1; pc = 32'h0000_0060; #1;
    chk("abort_stall0", stall, 1);
    @(negedge clk); #1;
    chk("abort_men1", men, 1);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("abort_men", men, 0);
    chk("abort_stall", stall, 0);
    chk("abort_instr", instr, NOP);
    @(negedge clk); rst_n = 1'b1; req = 1'b0;
    @(negedge clk); ack = 1'b1; mdata = line_of(32'h0000_0060); #1;
    chk("stale_men", men, 0);
    chk("stale_stall", stall, 0);
    @(negedge clk); ack = 1'b0;
    miss(32'h0000_0060, 1, 1'b0);

    // Ack in IDLE with junk data must not disturb a resident line.
    @(negedge clk); req = 1'b1; pc = 32'h0000_0060; ack = 1'b1; mdata = rand_line();
    exp_q.push_back(word_of(32'h0000_0060));
    #1;
    chk("idle_ack_stall", stall, 0);
    pop_chk("idle_ack_instr");
    @(negedge clk); ack = 1'b0;
    hit(32'h0000_0060);
    hit(32'h0000_007C);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
